// File: rtl/run_detect_pkg.sv
// Shared constants and helpers for the time-multiplexed run detector.
package run_detect_pkg;

  // Default channel count and run length used when a parent does not override them.
  localparam int DEFAULT_N       = 4;
  localparam int DEFAULT_RUN_LEN = 2;

  // Width of a per-channel run counter able to hold 0..run_len.
  function automatic int cnt_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_detect_sched_if.sv
// Bundle of the per-channel requester signals and the per-channel run flags.
interface run_detect_sched_if
  import run_detect_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic [N-1:0] req_valid;
  logic [N-1:0] req_bit;
  logic [N-1:0] req_ready;
  logic [N-1:0] clear;
  logic [N-1:0] match;
  logic [N-1:0] match_valid;

  // Requester / consumer side: offers bits and clears, observes grants and flags.
  modport master (
    output req_valid,
    output req_bit,
    output clear,
    input  req_ready,
    input  match,
    input  match_valid
  );

  // Detector side.
  modport slave (
    input  req_valid,
    input  req_bit,
    input  clear,
    output req_ready,
    output match,
    output match_valid
  );

endinterface

// File: rtl/run_detect_sched_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible channel after ptr.
module rr_arbiter
  import run_detect_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]         eligible_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  // Scan ptr+1, ptr+2, ... with wrap; the last granted channel gets lowest priority.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int off = 1; off <= N; off++) begin
      idx = PW'((int'(ptr_i) + off) % N);
      if (!found && eligible_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/run_detect_sched.sv
// Shared run detector: one arbitrated bit per cycle updates that channel's saved
// run count; match flags stay up while a channel's count sits at RUN_LEN.
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int RUN_LEN = DEFAULT_RUN_LEN
) (
  input logic              clk,
  input logic              reset,
  run_detect_sched_if.slave bus
);

  localparam int            PW      = $clog2(N);
  localparam int            CW      = cnt_width(RUN_LEN);
  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

  logic [N-1:0]  eligible;
  logic [N-1:0]  grant;
  logic [PW-1:0] grant_idx;
  logic          grant_any;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q [N];
  logic [CW-1:0] count_d [N];
  logic [N-1:0]  match_q, match_d;
  logic [N-1:0]  match_valid_q;

  // A channel being cleared is masked so the clear always beats its request.
  assign eligible = bus.req_valid & ~bus.clear;

  rr_arbiter #(.N(N)) u_arb (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign grant_any       = |grant;
  assign bus.req_ready   = grant;
  assign bus.match       = match_q;
  assign bus.match_valid = match_valid_q;

  // Pointer only advances on an accept so idle cycles keep fairness intact.
  assign ptr_d = grant_any ? grant_idx : ptr_q;

  // Next context per channel: clear wins, accepted bit extends or breaks the run.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      count_d[i] = count_q[i];
      if (bus.clear[i]) begin
        count_d[i] = '0;
      end else if (grant[i]) begin
        if (bus.req_bit[i]) begin
          count_d[i] = (count_q[i] == RUN_MAX) ? RUN_MAX : count_q[i] + CW'(1);
        end else begin
          count_d[i] = '0;
        end
      end
      match_d[i] = (count_d[i] == RUN_MAX);
    end
  end

  // Context, pointer and output flags; reset restarts arbitration at channel 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= PW'(N - 1);
      match_q       <= '0;
      match_valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      match_q       <= match_d;
      match_valid_q <= grant;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: two instances (RUN_LEN 2 and 3) share one stimulus
// stream and are compared every cycle against a behavioural per-channel model.
module tb_run_detect_sched;
  import run_detect_pkg::*;

  localparam int N    = 4;
  localparam int RL_A = 2;
  localparam int RL_B = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] reqValid;
  logic [N-1:0] reqBit;
  logic [N-1:0] clearVec;

  int checks   = 0;
  int failures = 0;

  int           mCount [2][N];
  int           mPtr;
  logic [N-1:0] mMv;

  run_detect_sched_if #(.N(N)) busA ();
  run_detect_sched_if #(.N(N)) busB ();

  assign busA.req_valid = reqValid;
  assign busA.req_bit   = reqBit;
  assign busA.clear     = clearVec;
  assign busB.req_valid = reqValid;
  assign busB.req_bit   = reqBit;
  assign busB.clear     = clearVec;

  run_detect_sched #(.N(N), .RUN_LEN(RL_A)) dutA (.clk(clk), .reset(reset), .bus(busA));
  run_detect_sched #(.N(N), .RUN_LEN(RL_B)) dutB (.clk(clk), .reset(reset), .bus(busB));

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Grant the model would give: first valid, uncleared channel after the last one granted.
  function automatic logic [N-1:0] expReady(input logic [N-1:0] v, input logic [N-1:0] c,
                                            input int p);
    logic [N-1:0] r;
    r = '0;
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (p + off) % N;
      if (v[i] && !c[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // A channel matches while its modelled run length has reached the target.
  function automatic logic [N-1:0] expMatch(input int d);
    logic [N-1:0] m;
    int lim;
    lim = (d == 0) ? RL_A : RL_B;
    for (int i = 0; i < N; i++) m[i] = (mCount[d][i] == lim);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] b,
                               input logic [N-1:0] c);
    reqValid = v;
    reqBit   = b;
    clearVec = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearAll();
    applyStimulus('0, '0, '1);
    step();
    applyStimulus('0, '0, '0);
  endtask

  // Behavioural model: run lengths per channel for both target lengths.
  always @(posedge clk or posedge reset) begin : modelUpd
    logic [N-1:0] g;
    int lim;
    if (reset) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++) mCount[d][i] <= 0;
      mPtr <= N - 1;
      mMv  <= '0;
    end else begin
      g = expReady(reqValid, clearVec, mPtr);
      for (int i = 0; i < N; i++) if (g[i]) mPtr <= i;
      for (int d = 0; d < 2; d++) begin
        lim = (d == 0) ? RL_A : RL_B;
        for (int i = 0; i < N; i++) begin
          if (clearVec[i]) mCount[d][i] <= 0;
          else if (g[i]) mCount[d][i] <= reqBit[i] ? ((mCount[d][i] + 1 > lim) ? lim : mCount[d][i] + 1) : 0;
        end
      end
      mMv <= g;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("readyA", 32'(busA.req_ready), 32'(expReady(reqValid, clearVec, mPtr)));
      checkOutput("readyB", 32'(busB.req_ready), 32'(expReady(reqValid, clearVec, mPtr)));
      checkOutput("matchA", 32'(busA.match), 32'(expMatch(0)));
      checkOutput("matchB", 32'(busB.match), 32'(expMatch(1)));
      checkOutput("mvA", 32'(busA.match_valid), 32'(mMv));
      checkOutput("mvB", 32'(busB.match_valid), 32'(mMv));
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin : stim
    logic [5:0] t2Bits;
    logic [5:0] t2ExpA;
    logic [5:0] t2ExpB;
    logic [4:0] t3ExpA;
    logic [4:0] t3ExpB;
    t2Bits = 6'b111011;
    t2ExpA = 6'b110010;
    t2ExpB = 6'b100000;
    t3ExpA = 5'b11110;
    t3ExpB = 5'b11100;

    reset = 1'b1;
    applyStimulus('0, '0, '0);
    #12;
    @(negedge clk);
    checkOutput("reset matchA", 32'(busA.match), 32'h0);
    checkOutput("reset mvA", 32'(busA.match_valid), 32'h0);
    reset = 1'b0;
    step();

    // All channels busy with 1s: strict rotation from channel 0.
    applyStimulus(4'b1111, 4'b1111, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("t1 grant", 32'(busA.req_ready), 32'(1 << (k % 4)));
      checkOutput("t1 matchA", 32'(busA.match), (k < 5) ? 32'h0 : 32'((1 << (k - 4)) - 1));
      if (k >= 1) checkOutput("t1 mv", 32'(busA.match_valid), 32'(1 << ((k - 1) % 4)));
      step();
    end
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("t1 final matchA", 32'(busA.match), 32'hF);
    checkOutput("t1 final matchB", 32'(busB.match), 32'h0);
    checkOutput("t1 final mv", 32'(busA.match_valid), 32'h8);
    step();
    @(negedge clk);
    checkOutput("t1 idle matchA", 32'(busA.match), 32'hF);
    checkOutput("t1 idle mv", 32'(busA.match_valid), 32'h0);
    clearAll();

    // Channel 2 alone, bits 1,1,0,1,1,1.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0100, {1'b0, t2Bits[k], 2'b00}, 4'b0000);
      @(negedge clk);
      checkOutput("t2 ready", 32'(busA.req_ready), 32'h4);
      if (k > 0) begin
        checkOutput("t2 matchA", 32'(busA.match[2]), 32'(t2ExpA[k-1]));
        checkOutput("t2 matchB", 32'(busB.match[2]), 32'(t2ExpB[k-1]));
      end
      step();
    end
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("t2 last matchA", 32'(busA.match[2]), 32'(t2ExpA[5]));
    checkOutput("t2 last matchB", 32'(busB.match[2]), 32'(t2ExpB[5]));
    clearAll();

    // Channel 1 alone, five 1s: saturation for both run lengths.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 4'b0010, 4'b0000);
      @(negedge clk);
      if (k > 0) begin
        checkOutput("t3 matchA", 32'(busA.match[1]), 32'(t3ExpA[k-1]));
        checkOutput("t3 matchB", 32'(busB.match[1]), 32'(t3ExpB[k-1]));
      end
      step();
    end
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("t3 sat matchB", 32'(busB.match[1]), 32'h1);
    clearAll();

    // Clear beats a simultaneous request on a matching channel.
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    step();
    step();
    applyStimulus(4'b0001, 4'b0001, 4'b0001);
    @(negedge clk);
    checkOutput("t4 pre matchA", 32'(busA.match[0]), 32'h1);
    checkOutput("t4 clear ready", 32'(busA.req_ready), 32'h0);
    step();
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("t4 post matchA", 32'(busA.match[0]), 32'h0);
    checkOutput("t4 post mv", 32'(busA.match_valid[0]), 32'h0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    step();
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("t4 restart matchA", 32'(busA.match[0]), 32'h0);
    clearAll();

    // Pointer at 3, requests on 1 and 3 alternate.
    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("t5 grant3", 32'(busA.req_ready), 32'h8);
    step();
    applyStimulus(4'b1010, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("t5 grant1", 32'(busA.req_ready), 32'h2);
    step();
    @(negedge clk);
    checkOutput("t5 grant3 again", 32'(busA.req_ready), 32'h8);
    step();
    clearAll();

    // Async reset in the middle of activity on channels 1 and 2.
    applyStimulus(4'b0110, 4'b0110, 4'b0000);
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    checkOutput("t6 pre matchA", 32'(busA.match), 32'h6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6 rst matchA", 32'(busA.match), 32'h0);
    checkOutput("t6 rst mvA", 32'(busA.match_valid), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6 first grant", 32'(busA.req_ready), 32'h1);
    step();
    @(negedge clk);
    checkOutput("t6 second grant", 32'(busA.req_ready), 32'h2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_detect_sched.md
# run_detect_sched

Time-multiplexed run detector shared between N serial requesters. Each requester offers one bit per transfer over a valid/ready handshake. A round-robin scheduler grants one requester per cycle to a single shared detector datapath. The datapath updates that requester's saved context and flags when the requester has delivered RUN_LEN or more consecutive 1s. The block sits between the serial input channels and the consumers that need per-channel run flags, replacing N dedicated detector FSMs.

## Interface
- N, 4, number of requesters (2..16)
- RUN_LEN, 2, consecutive 1s required to assert match (1..15)
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- req_valid  in  N  per-channel bit offered
- req_bit  in  N  per-channel data bit, sampled on accept
- req_ready  out  N  one-hot grant, combinational, at most one bit set
- clear  in  N  synchronous per-channel context clear
- match  out  N  registered; high while channel run count equals RUN_LEN
- match_valid  out  N  registered; one-cycle pulse the cycle after a channel's bit is accepted

## Operation
- Context per channel: count register, width CW = $clog2(RUN_LEN+1), saturating at RUN_LEN.
- Eligibility: channel i is eligible when req_valid[i] && !clear[i].
- Arbitration: round-robin from pointer ptr (last granted index). Grant the first eligible channel searching ptr+1, ptr+2, … with wrap modulo N. No eligible channel means req_ready = 0.
- Accept: req_valid[i] && req_ready[i]. Exactly zero or one accept per cycle.
- On accept of channel g:
  - count[g] <= req_bit[g] ? min(count[g]+1, RUN_LEN) : 0
  - ptr <= g
  - match_valid[g] <= 1
- Channels not accepted: count held; match_valid <= 0.
- match[i] <= (next count[i] == RUN_LEN). This is a Moore flag of the stored context, so it stays high across idle cycles until a 0 bit or a clear.
- clear[i]: count[i] <= 0 and match[i] <= 0 at the next edge. The channel is masked from arbitration that cycle, so clear wins over a simultaneous request.
- ptr does not move when nothing is accepted.
- Saturation: further 1s at count = RUN_LEN keep count at RUN_LEN and match high. No wrap.

## Timing
- reset (async): every count = 0, ptr = N-1 (channel 0 has first priority), match = 0, match_valid = 0.
- req_ready depends only on req_valid, clear and ptr. It must not depend on req_bit.
- Latency: a bit accepted at edge k updates match and pulses match_valid after edge k, visible in cycle k+1.
- Throughput: 1 bit/cycle aggregate. With all N channels continuously valid, each channel is granted exactly once every N cycles.
- A requester may hold req_valid across cycles without being granted; req_bit must stay stable until accepted.
- Reset deasserted mid-stream: all contexts restart from 0 and arbitration restarts at channel 0.

## Structure
- Package run_detect_pkg holds:
  - the count-width function cnt_width(RUN_LEN) = $clog2(RUN_LEN+1)
  - default N and RUN_LEN constants
- Sub-module rr_arbiter #(N):
  - inputs: eligible vector, ptr
  - outputs: one-hot grant and encoded grant index
  - purely combinational; ptr register stays in the parent.
- The parent holds the context array, the ptr register and the output registers.

## Test plan
- After reset, req_valid = 4'b1111, req_bit = 4'b1111 held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. match[i] rises in the cycle after channel i's second grant (cycles 5..8). match_valid shows exactly one bit per cycle.
- Channel 2 only, bits 1,1,0,1,1,1 on consecutive cycles -> match[2] = 0,1,0,0,1,1 in cycles 1..6. req_ready = 4'b0100 throughout.
- RUN_LEN = 3, channel 1 bits 1,1,1,1,1 -> count saturates at 3. match[1] goes high in the cycle after the third bit and stays high.
- Channel 0 at match = 1, then clear[0] = 1 with req_valid[0] = 1 for one cycle -> req_ready[0] = 0 that cycle. Next cycle match[0] = 0, count 0, match_valid[0] = 0.
- ptr = 3 (just granted 3), req_valid = 4'b1010 -> grant channel 1. Next cycle with the same request -> grant channel 3.
- Async reset asserted mid-run with match = 4'b0110 -> match = 0 and match_valid = 0 immediately. The first grant after release goes to channel 0 when it is valid.
